wb_snoop_arbiter_rr: RTL and testbench
======================================

Name: wb_snoop_arbiter_rr

Overview:
- Parametrised successor to the single-grant snoop arbiter: NUM_CORES Wishbone masters share one Wishbone slave (memory) through round-robin arbitration.
- Reads first snoop all other cores. A hit is forwarded core-to-core; a miss or a snoop timeout falls back to memory.
- Writes optionally broadcast an invalidate snoop before the memory access.
- Sits between the per-core L1 data-cache Wishbone ports and the shared memory interconnect.

Parameters:
- NUM_CORES, 4, number of masters (1..16).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- SNOOP_TIMEOUT, 16, snoop-window cycles before memory fallback (>=2).
- INVALIDATE_ON_WRITE, 1, 1 = broadcast invalidate before each write transaction.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- wbm_adr_i  in  NUM_CORES*AW  master addresses (core k at [k*AW+:AW])
- wbm_dat_i  in  NUM_CORES*DW  master write data
- wbm_sel_i  in  NUM_CORES*DW/8  byte selects
- wbm_we_i / wbm_cyc_i / wbm_stb_i  in  NUM_CORES each  per-master strobes
- wbm_cti_i  in  NUM_CORES*3  cycle type
- wbm_bte_i  in  NUM_CORES*2  burst type
- wbm_dat_o  out  NUM_CORES*DW  read data
- wbm_ack_o / wbm_err_o / wbm_rty_o  out  NUM_CORES each  terminations
- wbs_adr_o  out  AW  slave address; wbs_dat_o  out  DW; wbs_sel_o  out  DW/8
- wbs_we_o / wbs_cyc_o / wbs_stb_o  out  1 each; wbs_cti_o  out  3; wbs_bte_o  out  2
- wbs_dat_i  in  DW; wbs_ack_i / wbs_err_i / wbs_rty_i  in  1 each
- snoop_adr_o  out  AW  broadcast snoop address
- snoop_type_o  out  2  00 idle, 01 read, 10 invalidate
- snoop_req_o  out  NUM_CORES  per-core snoop request; requester bit is always 0
- snoop_ack_i  in  NUM_CORES  per-core snoop done (1-cycle pulse or level)
- snoop_valid_dat_i  in  NUM_CORES  qualifies snooped_dat_i with snoop_ack_i
- snooped_dat_i  in  NUM_CORES*DW  snoop data
- grant_o  out  NUM_CORES  one-hot current owner; 0 in IDLE
- snoop_timeout_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (asynchronous, wb_rst_n_i=0):
  - state=IDLE, grant_o=0, rr_ptr=0; all wbs_*, wbm_*_o and snoop_*_o outputs = 0; counters and ack_seen cleared.
  - Takes effect mid-transaction; no termination is issued for an aborted cycle.
- One-hot states: IDLE, SNOOP_RD, SNOOP_INV, FORWARD, MEM_ACCESS.
- IDLE:
  - Requesters = cyc&stb. The winner is the first requester at index >= rr_ptr, wrapping modulo NUM_CORES.
  - grant_o registers next cycle; rr_ptr = winner+1 (wraps to 0).
  - Next state:
    - read with cti in {000,111} and NUM_CORES>1 -> SNOOP_RD;
    - write with INVALIDATE_ON_WRITE=1 and NUM_CORES>1 -> SNOOP_INV;
    - otherwise (bursts cti=010, NUM_CORES=1, or writes with INVALIDATE_ON_WRITE=0) -> MEM_ACCESS.
- SNOOP_RD / SNOOP_INV:
  - snoop_adr_o = granted address; snoop_type_o = 01 or 10; snoop_req_o = ~grant_o, held until that core acks.
  - ack_seen accumulates snoop_ack_i (sticky). The counter increments each cycle from 0.
  - SNOOP_RD hit (ack&valid from a non-requester): capture snooped data of the lowest such index -> FORWARD. Same-cycle hits resolve to the lowest index.
  - All non-requester acks with no hit -> MEM_ACCESS.
  - Counter == SNOOP_TIMEOUT-1 without completion -> MEM_ACCESS, snoop_timeout_o=1 for one cycle. A late valid is ignored.
  - Requester drops cyc -> IDLE, no termination.
  - Acks and valids from the requester are ignored.
- FORWARD:
  - Drive wbm_dat_o[grant] = captured data and wbm_ack_o[grant]=1 for exactly one cycle; wbs_cyc_o stays 0.
  - Then -> IDLE if cyc dropped; else treat as a new request and re-enter arbitration.
- MEM_ACCESS:
  - Combinational pass-through of the granted master's adr/dat/sel/we/cyc/stb/cti/bte to wbs_*.
  - wbs_ack/err/rty_i and wbs_dat_i route to the granted lane only.
  - Stays for bursts while cyc is held; -> IDLE the cycle after the granted cyc falls.
- Ungranted lanes always see dat_o=0 and ack/err/rty=0.
- Latency:
  - Snoop hit: ack 3 cycles after request (IDLE, SNOOP_RD, FORWARD), given a same-cycle snoop ack.
  - Miss: 2 cycles plus memory latency.

Test Plan:
- Reset, all 4 cores read (cyc=stb=1111), cores 1,2,3 ack with valid=0 -> MEM_ACCESS with grant_o=0001; wbs_ack_i=1 with wbs_dat_i=0x1 gives wbm_ack_o=0001 and lane0 data 0x1.
- Grant owner on core0 read; core2 and core3 ack valid in the same cycle with data 0x40/0x50 -> core0 receives 0x40 with a one-cycle ack; wbs_cyc_o never 1; snoop_req_o=1110.
- Core1 snoop never acks, SNOOP_TIMEOUT=16 -> snoop_timeout_o pulses at cycle 16 of the snoop, then MEM_ACCESS.
- Core2 write of 55, INVALIDATE_ON_WRITE=1 -> snoop_type_o=10 and snoop_req_o=1011 until acks, then wbs_we_o=1 and wbs_dat_o=55.
- Back-to-back requests from cores 3 and 0 with rr_ptr=3 -> grant order 1000, then 0001; rr_ptr wraps to 0, then 1.
- wb_rst_n_i low during SNOOP_RD -> all outputs 0 immediately; state IDLE after release; burst read with cti=010 bypasses snoop.

Source files
------------

// File: rtl/wb_snoop_arbiter_rr.sv
// Round-robin Wishbone arbiter: NUM_CORES L1 ports share one memory slave. Reads snoop the
// other cores first (hit = core-to-core forward), writes optionally broadcast an invalidate.
module wb_snoop_arbiter_rr #(
    parameter int unsigned NUM_CORES           = 4,
    parameter int unsigned AW                  = 32,
    parameter int unsigned DW                  = 32,
    parameter int unsigned SNOOP_TIMEOUT       = 16,
    parameter bit          INVALIDATE_ON_WRITE = 1'b1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic [NUM_CORES*AW-1:0]   wbm_adr_i,
    input  logic [NUM_CORES*DW-1:0]   wbm_dat_i,
    input  logic [NUM_CORES*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_CORES-1:0]      wbm_we_i,
    input  logic [NUM_CORES-1:0]      wbm_cyc_i,
    input  logic [NUM_CORES-1:0]      wbm_stb_i,
    input  logic [NUM_CORES*3-1:0]    wbm_cti_i,
    input  logic [NUM_CORES*2-1:0]    wbm_bte_i,
    output logic [NUM_CORES*DW-1:0]   wbm_dat_o,
    output logic [NUM_CORES-1:0]      wbm_ack_o,
    output logic [NUM_CORES-1:0]      wbm_err_o,
    output logic [NUM_CORES-1:0]      wbm_rty_o,
    output logic [AW-1:0]             wbs_adr_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [DW/8-1:0]           wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [DW-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [AW-1:0]             snoop_adr_o,
    output logic [1:0]                snoop_type_o,
    output logic [NUM_CORES-1:0]      snoop_req_o,
    input  logic [NUM_CORES-1:0]      snoop_ack_i,
    input  logic [NUM_CORES-1:0]      snoop_valid_dat_i,
    input  logic [NUM_CORES*DW-1:0]   snooped_dat_i,
    output logic [NUM_CORES-1:0]      grant_o,
    output logic                      snoop_timeout_o
);
    localparam int unsigned PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CW = $clog2(SNOOP_TIMEOUT);
    localparam int unsigned SW = DW / 8;

    typedef enum logic [4:0] {
        StIdle      = 5'b00001,
        StSnoopRd   = 5'b00010,
        StSnoopInv  = 5'b00100,
        StForward   = 5'b01000,
        StMemAccess = 5'b10000
    } state_e;

    state_e               r_state;
    logic [NUM_CORES-1:0] r_grant, r_ack_seen;
    logic [PW-1:0]        r_gidx, r_rr_ptr;
    logic [CW-1:0]        r_cnt;
    logic [DW-1:0]        r_fwd_dat;

    logic [NUM_CORES-1:0] w_req, w_win_oh, w_others, w_hit_vec;
    logic [PW-1:0]        w_win_idx, w_hi_idx, w_lo_idx, w_rr_next;
    logic                 w_win_vld, w_hi_vld, w_win_rd, w_gcyc, w_all_ack, w_rd_hit;
    logic                 w_cnt_exp, w_in_snoop;
    logic [2:0]           w_win_cti;
    logic [DW-1:0]        w_hit_dat;
    state_e               w_arb_state;

    assign w_req = wbm_cyc_i & wbm_stb_i;

    // Winner: lowest requester at or above rr_ptr, otherwise lowest requester overall.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
            if (w_req[k]) begin
                w_lo_idx = PW'(k);
                if (k >= int'(r_rr_ptr)) begin
                    w_hi_idx = PW'(k);
                    w_hi_vld = 1'b1;
                end
            end
        end
        w_win_vld = |w_req;
        w_win_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
        w_win_oh  = '0;
        w_win_oh[w_win_idx] = 1'b1;
    end

    assign w_win_rd  = ~wbm_we_i[w_win_idx];
    assign w_win_cti = wbm_cti_i[w_win_idx*3 +: 3];
    assign w_rr_next = (w_win_idx == PW'(NUM_CORES - 1)) ? '0 : w_win_idx + 1'b1;

    always_comb begin
        if (NUM_CORES > 1 && w_win_rd && (w_win_cti == 3'b000 || w_win_cti == 3'b111)) begin
            w_arb_state = StSnoopRd;
        end else if (NUM_CORES > 1 && !w_win_rd && INVALIDATE_ON_WRITE) begin
            w_arb_state = StSnoopInv;
        end else begin
            w_arb_state = StMemAccess;
        end
    end

    assign w_others   = ~r_grant;
    assign w_hit_vec  = snoop_ack_i & snoop_valid_dat_i & w_others;
    assign w_all_ack  = ((r_ack_seen | snoop_ack_i) & w_others) == w_others;
    assign w_gcyc     = wbm_cyc_i[r_gidx];
    assign w_cnt_exp  = (r_cnt == CW'(SNOOP_TIMEOUT - 1));
    assign w_in_snoop = (r_state == StSnoopRd) || (r_state == StSnoopInv);
    assign w_rd_hit   = (r_state == StSnoopRd) && (|w_hit_vec);

    always_comb begin
        w_hit_dat = '0;
        for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
            if (w_hit_vec[k]) w_hit_dat = snooped_dat_i[k*DW +: DW];
        end
    end

    assign snoop_timeout_o = w_in_snoop && w_gcyc && !w_rd_hit && !w_all_ack && w_cnt_exp;
    assign grant_o         = r_grant;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_ack_seen <= '0;
            r_fwd_dat  <= '0;
        end else begin
            unique case (r_state)
                StIdle, StForward: begin
                    // A master still holding cyc after a forward is re-arbitrated directly.
                    if (w_win_vld && (r_state == StIdle || w_gcyc)) begin
                        r_state  <= w_arb_state;
                        r_grant  <= w_win_oh;
                        r_gidx   <= w_win_idx;
                        r_rr_ptr <= w_rr_next;
                    end else begin
                        r_state <= StIdle;
                        r_grant <= '0;
                    end
                    r_cnt      <= '0;
                    r_ack_seen <= '0;
                end
                StSnoopRd, StSnoopInv: begin
                    r_ack_seen <= r_ack_seen | snoop_ack_i;
                    r_cnt      <= r_cnt + 1'b1;
                    if (!w_gcyc) begin
                        r_state <= StIdle;
                        r_grant <= '0;
                    end else if (w_rd_hit) begin
                        r_state   <= StForward;
                        r_fwd_dat <= w_hit_dat;
                    end else if (w_all_ack || w_cnt_exp) begin
                        r_state <= StMemAccess;
                    end
                end
                StMemAccess: begin
                    if (!w_gcyc) begin
                        r_state <= StIdle;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        wbm_dat_o    = '0;
        wbm_ack_o    = '0;
        wbm_err_o    = '0;
        wbm_rty_o    = '0;
        wbs_adr_o    = '0;
        wbs_dat_o    = '0;
        wbs_sel_o    = '0;
        wbs_we_o     = 1'b0;
        wbs_cyc_o    = 1'b0;
        wbs_stb_o    = 1'b0;
        wbs_cti_o    = '0;
        wbs_bte_o    = '0;
        snoop_adr_o  = '0;
        snoop_type_o = 2'b00;
        snoop_req_o  = '0;
        unique case (r_state)
            StSnoopRd, StSnoopInv: begin
                snoop_adr_o  = wbm_adr_i[r_gidx*AW +: AW];
                snoop_type_o = (r_state == StSnoopRd) ? 2'b01 : 2'b10;
                snoop_req_o  = w_others & ~r_ack_seen;
            end
            StForward: begin
                wbm_dat_o[r_gidx*DW +: DW] = r_fwd_dat;
                wbm_ack_o[r_gidx]          = 1'b1;
            end
            StMemAccess: begin
                wbs_adr_o = wbm_adr_i[r_gidx*AW +: AW];
                wbs_dat_o = wbm_dat_i[r_gidx*DW +: DW];
                wbs_sel_o = wbm_sel_i[r_gidx*SW +: SW];
                wbs_we_o  = wbm_we_i[r_gidx];
                wbs_cyc_o = wbm_cyc_i[r_gidx];
                wbs_stb_o = wbm_stb_i[r_gidx];
                wbs_cti_o = wbm_cti_i[r_gidx*3 +: 3];
                wbs_bte_o = wbm_bte_i[r_gidx*2 +: 2];
                wbm_dat_o[r_gidx*DW +: DW] = wbs_dat_i;
                wbm_ack_o[r_gidx]          = wbs_ack_i;
                wbm_err_o[r_gidx]          = wbs_err_i;
                wbm_rty_o[r_gidx]          = wbs_rty_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_wb_snoop_arbiter_rr.sv
// Directed bench for wb_snoop_arbiter_rr: 4 cores, 32-bit bus, timeout 16, invalidate on write.
module tb_wb_snoop_arbiter_rr;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [127:0]  m_adr, m_dat, s_dat, wbm_dat_o;
    logic [15:0]   m_sel;
    logic [3:0]    m_we, m_cyc, m_stb, wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [11:0]   m_cti;
    logic [7:0]    m_bte;
    logic [31:0]   wbs_adr_o, wbs_dat_o, wbs_dat_i, snoop_adr_o;
    logic [3:0]    wbs_sel_o, snoop_req_o, snoop_ack, snoop_vld, grant_o;
    logic          wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic [2:0]    wbs_cti_o;
    logic [1:0]    wbs_bte_o, snoop_type_o;
    logic          snoop_timeout_o;

    typedef struct packed {
        logic [3:0]   ack;
        logic [127:0] dat;
    } resp_t;
    resp_t sb_q[$];

    int n_vec = 0;
    int n_fail = 0;
    int mem_cycles = 0;
    int lat;
    int first_to;
    int n_to;
    int mem_before;

    always #5 clk = ~clk;

    always @(posedge clk) if (wbs_cyc_o) mem_cycles <= mem_cycles + 1;

    wb_snoop_arbiter_rr #(
        .NUM_CORES(N), .AW(32), .DW(32), .SNOOP_TIMEOUT(16), .INVALIDATE_ON_WRITE(1'b1)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o),
        .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i),
        .snoop_adr_o(snoop_adr_o), .snoop_type_o(snoop_type_o), .snoop_req_o(snoop_req_o),
        .snoop_ack_i(snoop_ack), .snoop_valid_dat_i(snoop_vld), .snooped_dat_i(s_dat),
        .grant_o(grant_o), .snoop_timeout_o(snoop_timeout_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0; s_dat = '0; snoop_ack = '0; snoop_vld = '0;
        wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    endtask

    task automatic set_master(input int k, input logic we, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [2:0] cti);
        m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = we;
        m_adr[k*32 +: 32] = adr; m_dat[k*32 +: 32] = dat;
        m_sel[k*4 +: 4] = 4'hf; m_cti[k*3 +: 3] = cti;
    endtask

    task automatic push(input int k, input logic [31:0] d);
        resp_t e;
        e.ack = '0;
        e.ack[k] = 1'b1;
        e.dat = '0;
        e.dat[k*32 +: 32] = d;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        resp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL %s: response observed %0h with empty scoreboard", tag, wbm_ack_o);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ack"}, {124'd0, wbm_ack_o}, {124'd0, e.ack});
            chk({tag, "_dat"}, wbm_dat_o, e.dat);
        end
    endtask

    // Waits for an ack, checks it against the scoreboard, then drops the answered master.
    task automatic wait_resp(input string tag, input int budget, output int latency);
        logic [3:0] ackv;
        latency = -1;
        for (int i = 0; i < budget; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (wbm_ack_o != '0) begin
                latency = i;
                break;
            end
        end
        if (latency < 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL %s: no ack within %0d cycles", tag, budget);
        end else begin
            ackv = wbm_ack_o;
            pop_check(tag);
            for (int k = 0; k < N; k++) begin
                if (ackv[k]) begin
                    m_cyc[k] = 1'b0;
                    m_stb[k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", {124'd0, grant_o}, 128'd0);
        chk("rst_wbs_cyc", {127'd0, wbs_cyc_o}, 128'd0);
        chk("rst_snoop_req", {124'd0, snoop_req_o}, 128'd0);
        chk("rst_ack", {124'd0, wbm_ack_o}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four read; three snoops miss, memory answers core 0.
        @(negedge clk);
        for (int k = 0; k < N; k++) set_master(k, 1'b0, 32'h100 + 32'(k) * 32'h10, '0, 3'b000);
        snoop_ack = 4'b1110;
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h1;
        push(0, 32'h1);
        @(negedge clk);
        #1;
        chk("miss_grant", {124'd0, grant_o}, 128'h1);
        chk("miss_snoop_req", {124'd0, snoop_req_o}, 128'he);
        chk("miss_snoop_type", {126'd0, snoop_type_o}, 128'h1);
        chk("miss_snoop_adr", {96'd0, snoop_adr_o}, 128'h100);
        wait_resp("miss_resp", 8, lat);
        chk("miss_latency", 128'(lat), 128'd1);
        idle_inputs();

        // Core 0 read hits in cores 2 and 3 together; lowest index supplies data.
        @(negedge clk);
        mem_before = mem_cycles;
        set_master(0, 1'b0, 32'h200, '0, 3'b000);
        snoop_ack = 4'b1100;
        snoop_vld = 4'b1100;
        s_dat[64 +: 32] = 32'h40;
        s_dat[96 +: 32] = 32'h50;
        push(0, 32'h40);
        @(negedge clk);
        #1;
        chk("hit_grant", {124'd0, grant_o}, 128'h1);
        chk("hit_snoop_req", {124'd0, snoop_req_o}, 128'he);
        wait_resp("hit_resp", 8, lat);
        chk("hit_latency", 128'(lat), 128'd1);
        idle_inputs();
        @(negedge clk);
        #1;
        chk("hit_ack_one_cycle", {124'd0, wbm_ack_o}, 128'd0);
        chk("hit_no_mem", 128'(mem_cycles - mem_before), 128'd0);

        // Core 2 read, core 1 never acks: timeout then memory; a late hit is ignored.
        @(negedge clk);
        set_master(2, 1'b0, 32'h300, '0, 3'b000);
        snoop_ack = 4'b1001;
        first_to = 0;
        n_to = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            #1;
            if (snoop_timeout_o) begin
                n_to++;
                if (first_to == 0) first_to = c;
            end
            if (c == 1) chk("to_snoop_req_c1", {124'd0, snoop_req_o}, 128'hb);
            if (c == 2) chk("to_snoop_req_c2", {124'd0, snoop_req_o}, 128'h2);
        end
        chk("to_first_cycle", 128'(first_to), 128'd16);
        chk("to_pulse_count", 128'(n_to), 128'd1);
        chk("to_mem_cyc", {127'd0, wbs_cyc_o}, 128'd1);
        chk("to_mem_adr", {96'd0, wbs_adr_o}, 128'h300);
        snoop_ack[1] = 1'b1;
        snoop_vld[1] = 1'b1;
        s_dat[32 +: 32] = 32'hbad;
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h33;
        push(2, 32'h33);
        wait_resp("to_resp", 8, lat);
        idle_inputs();

        // Core 2 write: invalidate snoop with acks arriving over two cycles.
        @(negedge clk);
        set_master(2, 1'b1, 32'h400, 32'h55, 3'b000);
        @(negedge clk);
        #1;
        chk("inv_snoop_type", {126'd0, snoop_type_o}, 128'h2);
        chk("inv_snoop_req", {124'd0, snoop_req_o}, 128'hb);
        chk("inv_no_mem", {127'd0, wbs_cyc_o}, 128'd0);
        snoop_ack = 4'b0011;
        @(negedge clk);
        #1;
        chk("inv_snoop_req_held", {124'd0, snoop_req_o}, 128'h8);
        snoop_ack = 4'b1000;
        @(negedge clk);
        snoop_ack = 4'b0000;
        #1;
        chk("inv_wbs_we", {127'd0, wbs_we_o}, 128'd1);
        chk("inv_wbs_dat", {96'd0, wbs_dat_o}, 128'h55);
        chk("inv_wbs_sel", {124'd0, wbs_sel_o}, 128'hf);
        chk("inv_snoop_idle", {126'd0, snoop_type_o}, 128'd0);
        wbs_ack_i = 1'b1;
        push(2, 32'h0);
        wait_resp("inv_resp", 8, lat);
        idle_inputs();

        // rr_ptr is 3: core 3 first, then core 0.
        @(negedge clk);
        set_master(3, 1'b0, 32'h530, '0, 3'b000);
        set_master(0, 1'b0, 32'h500, '0, 3'b000);
        snoop_ack = 4'b1111;
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h77;
        push(3, 32'h77);
        push(0, 32'h77);
        @(negedge clk);
        #1;
        chk("rr_grant_first", {124'd0, grant_o}, 128'h8);
        wait_resp("rr_resp_core3", 8, lat);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rr_grant_second", {124'd0, grant_o}, 128'h1);
        wait_resp("rr_resp_core0", 8, lat);
        idle_inputs();

        // rr_ptr now 1: core 1 beats core 0; dropping cyc mid-snoop aborts silently.
        @(negedge clk);
        set_master(0, 1'b0, 32'h600, '0, 3'b000);
        set_master(1, 1'b0, 32'h610, '0, 3'b000);
        @(negedge clk);
        #1;
        chk("rr_wrap_grant", {124'd0, grant_o}, 128'h2);
        idle_inputs();
        @(negedge clk);
        #1;
        chk("abort_grant", {124'd0, grant_o}, 128'd0);
        chk("abort_no_ack", {124'd0, wbm_ack_o}, 128'd0);

        // Reset asserted during a snoop read.
        @(negedge clk);
        set_master(1, 1'b0, 32'h700, '0, 3'b000);
        @(negedge clk);
        #1;
        chk("pre_rst_snoop_req", {124'd0, snoop_req_o}, 128'hd);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", {124'd0, grant_o}, 128'd0);
        chk("mid_rst_snoop_req", {124'd0, snoop_req_o}, 128'd0);
        chk("mid_rst_snoop_type", {126'd0, snoop_type_o}, 128'd0);
        chk("mid_rst_wbm_ack", {124'd0, wbm_ack_o}, 128'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_idle", {124'd0, grant_o}, 128'd0);

        // Burst reads bypass snooping; rr_ptr back at 0 picks core 1 over core 3.
        @(negedge clk);
        set_master(1, 1'b0, 32'h810, '0, 3'b010);
        set_master(3, 1'b0, 32'h830, '0, 3'b010);
        m_bte[3:2] = 2'b01;
        @(negedge clk);
        #1;
        chk("burst_grant", {124'd0, grant_o}, 128'h2);
        chk("burst_wbs_cyc", {127'd0, wbs_cyc_o}, 128'd1);
        chk("burst_wbs_adr", {96'd0, wbs_adr_o}, 128'h810);
        chk("burst_wbs_cti", {125'd0, wbs_cti_o}, 128'h2);
        chk("burst_wbs_bte", {126'd0, wbs_bte_o}, 128'h1);
        chk("burst_no_snoop", {124'd0, snoop_req_o}, 128'd0);
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'ha0;
        push(1, 32'ha0);
        #1;
        pop_check("burst_beat0");
        @(negedge clk);
        wbs_dat_i = 32'ha1;
        push(1, 32'ha1);
        #1;
        pop_check("burst_beat1");
        idle_inputs();
        @(negedge clk);
        #1;
        chk("end_idle", {124'd0, grant_o}, 128'd0);
        chk("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
